// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side sequencer for the CPU register file.
// Merges ALU and load write requests into a small in-order FIFO and
// drains one registered write per cycle toward the register file.
// A per-register pending mask lets decode stall on RAW hazards.
// Optional feature macro: WB_FORWARD_EN (forwarding of buffered data by
// register address). The default build has fwd_hit/fwd_data tied to 0.
module regfile_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [ADDR_W-1:0]         ld_rd,
  input  logic [DATA_W-1:0]         ld_data,
  input  logic                      wb_hold,
  output logic [ADDR_W-1:0]         rd_add,
  output logic [DATA_W-1:0]         write_data,
  output logic                      regf_write_CS,
  output logic [(2**ADDR_W)-1:0]    pending,
  output logic [$clog2(DEPTH):0]    fifo_count,
  input  logic [ADDR_W-1:0]         fwd_add,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2 ** ADDR_W;

  // FIFO storage, indexed by pointers that wrap naturally (DEPTH is a power of two)
  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic [CNT_W-1:0]  free_space;
  logic              alu_accept;
  logic              ld_accept;
  logic              alu_push;
  logic              ld_push;
  logic [1:0]        push_n;
  logic              pop;
  logic [PTR_W-1:0]  ld_slot;

  // Handshake decisions come only from the registered count; a pop in the
  // same cycle never creates extra room. The ALU owns the last free slot.
  always_comb begin
    free_space = CNT_W'(DEPTH) - fifo_count;
    alu_ready  = (free_space >= CNT_W'(1));
    ld_ready   = (free_space >= CNT_W'(2)) ||
                 ((free_space == CNT_W'(1)) && !alu_valid);
    alu_accept = alu_valid && alu_ready;
    ld_accept  = ld_valid && ld_ready;
    // Writes to x0 complete the handshake but are discarded here
    alu_push   = alu_accept && (alu_rd != '0);
    ld_push    = ld_accept && (ld_rd != '0);
    push_n     = {1'b0, alu_push} + {1'b0, ld_push};
    // The load lands behind the ALU entry so program order is preserved
    ld_slot    = wr_ptr + PTR_W'(alu_push);
    pop        = (fifo_count != '0) && !wb_hold;
  end

  // FIFO pointers, occupancy and the registered register-file write stage
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
      rd_add        <= '0;
      write_data    <= '0;
      regf_write_CS <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (alu_push) begin
        rd_mem[wr_ptr]   <= alu_rd;
        data_mem[wr_ptr] <= alu_data;
      end
      if (ld_push) begin
        rd_mem[ld_slot]   <= ld_rd;
        data_mem[ld_slot] <= ld_data;
      end
      wr_ptr <= wr_ptr + PTR_W'(push_n);

      if (pop) begin
        regf_write_CS <= 1'b1;
        rd_add        <= rd_mem[rd_ptr];
        write_data    <= data_mem[rd_ptr];
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end else begin
        regf_write_CS <= 1'b0;
      end

      fifo_count <= fifo_count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  // Pending mask: every buffered destination plus the one being written now
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < fifo_count) begin
        pending[rd_mem[rd_ptr + PTR_W'(k)]] = 1'b1;
      end
    end
    if (regf_write_CS) begin
      pending[rd_add] = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  // Forward the youngest buffered value for fwd_add; scanning oldest to
  // youngest after the output stage lets younger matches override older ones
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_add != '0) begin
      if (regf_write_CS && (rd_add == fwd_add)) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CNT_W'(k) < fifo_count) &&
            (rd_mem[rd_ptr + PTR_W'(k)] == fwd_add)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem[rd_ptr + PTR_W'(k)];
        end
      end
    end
  end
`else
  logic unused_fwd_add;
  assign unused_fwd_add = ^fwd_add;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = '0;
`endif

  // Unused width bits of NREG-sized mask are fully used; keep NREG referenced
  logic [NREG-1:0] unused_nreg_mask;
  assign unused_nreg_mask = pending;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed, table-driven bench for regfile_writeback.
// Define WB_FORWARD_EN to also exercise the forwarding path.
module tb_regfile_writeback;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wb_hold;
  logic [3:0]  rd_add;
  logic [31:0] write_data;
  logic        regf_write_CS;
  logic [15:0] pending;
  logic [2:0]  fifo_count;
  logic [3:0]  fwd_add;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int checks = 0;
  int errors = 0;

  regfile_writeback #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_hold(wb_hold), .rd_add(rd_add), .write_data(write_data),
    .regf_write_CS(regf_write_CS), .pending(pending), .fifo_count(fifo_count),
    .fwd_add(fwd_add), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [3:0]  lrd;
    logic [31:0] ldat;
    logic        hold;
    logic        exp_ar;
    logic        exp_lr;
    int          exp_cnt;
    logic        exp_we;
    logic [3:0]  exp_rd;
    logic [31:0] exp_wd;
    logic [15:0] exp_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [3:0] ard, logic [31:0] ad,
                              logic lv, logic [3:0] lrd, logic [31:0] ldat,
                              logic hold, logic ear, logic elr, int ecnt,
                              logic ewe, logic [3:0] erd, logic [31:0] ewd,
                              logic [15:0] ep);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.hold = hold;
    v.exp_ar = ear; v.exp_lr = elr; v.exp_cnt = ecnt;
    v.exp_we = ewe; v.exp_rd = erd; v.exp_wd = ewd; v.exp_pend = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                             input logic lv, input logic [3:0] lrd, input logic [31:0] ldat,
                             input logic hold);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    wb_hold = hold;
  endtask

  // Drive one vector at the falling edge, check readies before the rising
  // edge, then check registered state just after it
  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    driveInputs(v.av, v.ard, v.ad, v.lv, v.lrd, v.ldat, v.hold);
    fwd_add = v.ard;
    #1;
    checkOutput($sformatf("v%0d_alu_ready", idx), 64'(alu_ready), 64'(v.exp_ar));
    checkOutput($sformatf("v%0d_ld_ready", idx), 64'(ld_ready), 64'(v.exp_lr));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d_count", idx), 64'(fifo_count), 64'(v.exp_cnt));
    checkOutput($sformatf("v%0d_we", idx), 64'(regf_write_CS), 64'(v.exp_we));
    checkOutput($sformatf("v%0d_rd_add", idx), 64'(rd_add), 64'(v.exp_rd));
    checkOutput($sformatf("v%0d_wdata", idx), 64'(write_data), 64'(v.exp_wd));
    checkOutput($sformatf("v%0d_pending", idx), 64'(pending), 64'(v.exp_pend));
`ifndef WB_FORWARD_EN
    checkOutput($sformatf("v%0d_fwd_hit", idx), 64'(fwd_hit), 64'd0);
`endif
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: av ard ad | lv lrd ld | hold | ar lr | cnt we rd wd pending
    vecs.push_back(mk(1,  3, 32'hDEADBEEF, 0,  0, 32'h0,    0, 1, 1, 1, 0,  0, 32'h0,        16'h0008));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 1,  3, 32'hDEADBEEF, 16'h0008));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 0,  3, 32'hDEADBEEF, 16'h0000));
    vecs.push_back(mk(1,  1, 32'h11,       1,  2, 32'h22,   1, 1, 1, 2, 0,  3, 32'hDEADBEEF, 16'h0006));
    vecs.push_back(mk(1,  1, 32'h11,       1,  2, 32'h22,   1, 1, 1, 4, 0,  3, 32'hDEADBEEF, 16'h0006));
    vecs.push_back(mk(1,  1, 32'h33,       1,  2, 32'h44,   1, 0, 0, 4, 0,  3, 32'hDEADBEEF, 16'h0006));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 0, 0, 3, 1,  1, 32'h11,       16'h0006));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 2, 1,  2, 32'h22,       16'h0006));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 1, 1,  1, 32'h11,       16'h0006));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 1,  2, 32'h22,       16'h0004));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 0,  2, 32'h22,       16'h0000));
    vecs.push_back(mk(1,  4, 32'h44,       1,  5, 32'h55,   1, 1, 1, 2, 0,  2, 32'h22,       16'h0030));
    vecs.push_back(mk(1,  6, 32'h66,       0,  0, 32'h0,    1, 1, 1, 3, 0,  2, 32'h22,       16'h0070));
    vecs.push_back(mk(1,  7, 32'h77,       1,  8, 32'h88,   1, 1, 0, 4, 0,  2, 32'h22,       16'h00F0));
    vecs.push_back(mk(1,  9, 32'h99,       1, 10, 32'hAA,   1, 0, 0, 4, 0,  2, 32'h22,       16'h00F0));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 0, 0, 3, 1,  4, 32'h44,       16'h00F0));
    vecs.push_back(mk(0,  0, 32'h0,        1,  9, 32'h99,   1, 1, 1, 4, 0,  4, 32'h44,       16'h02E0));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 0, 0, 3, 1,  5, 32'h55,       16'h02E0));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 2, 1,  6, 32'h66,       16'h02C0));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 1, 1,  7, 32'h77,       16'h0280));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 1,  9, 32'h99,       16'h0200));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 0,  9, 32'h99,       16'h0000));
    vecs.push_back(mk(1,  0, 32'hFFFFFFFF, 0,  0, 32'h0,    0, 1, 1, 0, 0,  9, 32'h99,       16'h0000));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 0,  9, 32'h99,       16'h0000));
    vecs.push_back(mk(1, 10, 32'hA,        0,  0, 32'h0,    0, 1, 1, 1, 0,  9, 32'h99,       16'h0400));
    vecs.push_back(mk(0,  0, 32'h0,        1, 11, 32'hB,    0, 1, 1, 1, 1, 10, 32'hA,        16'h0C00));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 1, 11, 32'hB,        16'h0800));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 0, 11, 32'hB,        16'h0000));
    vecs.push_back(mk(1, 12, 32'hC,        1,  0, 32'hDEAD, 1, 1, 1, 1, 0, 11, 32'hB,        16'h1000));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 1, 12, 32'hC,        16'h1000));
    vecs.push_back(mk(0,  0, 32'h0,        0,  0, 32'h0,    0, 1, 1, 0, 0, 12, 32'hC,        16'h0000));

    reset = 1'b1;
    fwd_add = '0;
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("[TB] checking reset state");
    checkOutput("reset_count", 64'(fifo_count), 64'd0);
    checkOutput("reset_we", 64'(regf_write_CS), 64'd0);
    checkOutput("reset_rd_add", 64'(rd_add), 64'd0);
    checkOutput("reset_wdata", 64'(write_data), 64'd0);
    checkOutput("reset_pending", 64'(pending), 64'd0);
    checkOutput("reset_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("reset_ld_ready", 64'(ld_ready), 64'd1);
    checkOutput("reset_fwd_hit", 64'(fwd_hit), 64'd0);
    checkOutput("reset_fwd_data", 64'(fwd_data), 64'd0);

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Reset in the middle of a held, partly filled FIFO
    $display("[TB] reset mid-operation");
    @(negedge clk);
    driveInputs(1, 1, 32'h101, 1, 2, 32'h202, 1);
    stepCycle();
    @(negedge clk);
    driveInputs(1, 3, 32'h303, 0, 0, 32'h0, 1);
    stepCycle();
    checkOutput("midrst_fill_count", 64'(fifo_count), 64'd3);
    checkOutput("midrst_fill_pending", 64'(pending), 64'h000E);
    @(negedge clk);
    driveInputs(0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    stepCycle();
    @(negedge clk);
    reset = 1'b0;
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("midrst_count", 64'(fifo_count), 64'd0);
    checkOutput("midrst_pending", 64'(pending), 64'd0);
    checkOutput("midrst_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("midrst_ld_ready", 64'(ld_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput($sformatf("midrst_we_c%0d", c), 64'(regf_write_CS), 64'd0);
      checkOutput($sformatf("midrst_cnt_c%0d", c), 64'(fifo_count), 64'd0);
    end

    // Duplicate destination: in-order writes, youngest value forwarded
    $display("[TB] duplicate destination and forwarding");
    @(negedge clk);
    driveInputs(1, 5, 32'h1, 0, 0, 32'h0, 1);
    fwd_add = 4'd5;
    stepCycle();
    @(negedge clk);
    driveInputs(1, 5, 32'h2, 0, 0, 32'h0, 1);
    stepCycle();
    @(negedge clk);
    driveInputs(0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("dup_count", 64'(fifo_count), 64'd2);
    checkOutput("dup_pending", 64'(pending), 64'h0020);
`ifdef WB_FORWARD_EN
    checkOutput("fwd_hit_5", 64'(fwd_hit), 64'd1);
    checkOutput("fwd_data_5", 64'(fwd_data), 64'h2);
    fwd_add = 4'd0;
    #1;
    checkOutput("fwd_hit_0", 64'(fwd_hit), 64'd0);
    fwd_add = 4'd6;
    #1;
    checkOutput("fwd_hit_6", 64'(fwd_hit), 64'd0);
    fwd_add = 4'd5;
`else
    checkOutput("nofwd_hit", 64'(fwd_hit), 64'd0);
    checkOutput("nofwd_data", 64'(fwd_data), 64'd0);
`endif
    wb_hold = 1'b0;
    stepCycle();
    checkOutput("dup_w1_we", 64'(regf_write_CS), 64'd1);
    checkOutput("dup_w1_rd", 64'(rd_add), 64'd5);
    checkOutput("dup_w1_data", 64'(write_data), 64'h1);
`ifdef WB_FORWARD_EN
    checkOutput("fwd_mix_data", 64'(fwd_data), 64'h2);
`endif
    stepCycle();
    checkOutput("dup_w2_we", 64'(regf_write_CS), 64'd1);
    checkOutput("dup_w2_rd", 64'(rd_add), 64'd5);
    checkOutput("dup_w2_data", 64'(write_data), 64'h2);
`ifdef WB_FORWARD_EN
    checkOutput("fwd_out_hit", 64'(fwd_hit), 64'd1);
    checkOutput("fwd_out_data", 64'(fwd_data), 64'h2);
`endif
    stepCycle();
    checkOutput("dup_idle_we", 64'(regf_write_CS), 64'd0);
    checkOutput("dup_idle_pending", 64'(pending), 64'd0);
    checkOutput("dup_idle_fwd_hit", 64'(fwd_hit), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Write-side sequencer for the CPU register file.
- Collects register-write requests from two producers, the ALU result path and the load/data-memory return path, over valid/ready handshakes.
- Buffers accepted requests in a small in-order FIFO.
- Drives exactly one register write per cycle toward the register file (rd_add / write_data / regf_write_CS).
- Publishes a per-register pending mask so decode can stall on RAW hazards.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register address width (2**ADDR_W architectural registers)
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- alu_valid  in  1  ALU write request valid
- alu_ready  out  1  ALU request accepted this cycle when valid & ready
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load write request valid
- ld_ready  out  1  load request accepted when valid & ready
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- wb_hold  in  1  freeze draining (no pop, no write)
- rd_add  out  ADDR_W  register-file write address
- write_data  out  DATA_W  register-file write data
- regf_write_CS  out  1  register-file write enable
- pending  out  2**ADDR_W  bit r = 1 while any write to register r is buffered or on the output stage
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
- fwd_add  in  ADDR_W  forward query address (used only with WB_FORWARD_EN)
- fwd_hit  out  1  forward hit
- fwd_data  out  DATA_W  forwarded data

Behaviour:
- Reset (synchronous, checked first): FIFO empty, pointers 0, fifo_count=0, rd_add=0, write_data=0, regf_write_CS=0, pending=0, fwd_hit=0, fwd_data=0. Reset mid-operation discards all buffered requests; nothing is written afterwards.
- Free space S = DEPTH - fifo_count, taken from registered count. A pop in the same cycle does not add space.
- alu_ready = (S >= 1).
- ld_ready = (S >= 2), or (S == 1 and alu_valid == 0). ALU has priority for the last slot.
- Both accepted in the same cycle: ALU entry enqueued first, load entry second (program order).
- Request with rd == 0: handshake completes normally, but the entry is dropped. It is never enqueued, never counted, never sets pending.
- Drain, each rising edge when not in reset:
  - FIFO non-empty and wb_hold == 0: pop head into output stage; regf_write_CS=1, rd_add/write_data = head fields.
  - Otherwise: regf_write_CS=0; rd_add/write_data hold their previous values.
- Outputs are registered.
- Latency: a request accepted at edge k into an empty FIFO appears on regf_write_CS at edge k+1 (1 cycle after acceptance). No combinational bypass.
- Push and pop may occur in the same cycle. fifo_count updates by pushes minus pop.
- Pointers wrap modulo DEPTH.
- Full: fifo_count == DEPTH, so both readies are 0. Empty: no write is issued.
- pending is combinational: OR of one-hot(rd) over valid FIFO entries, plus one-hot(rd_add) when regf_write_CS == 1.
- Duplicate destinations in the FIFO are legal. They are written in order, so the last write wins.

Optional Feature:
WB_FORWARD_EN
- Defined:
  - fwd_hit = 1 when fwd_add != 0 and fwd_add matches a valid FIFO entry or the active output stage.
  - fwd_data = data of the youngest matching entry. Priority is youngest FIFO entry, then older entries, then the output stage.
  - Combinational from state.
- Undefined: fwd_hit=0 and fwd_data=0 constantly; fwd_add ignored; no comparator logic synthesized.

Test Plan:
- Single ALU write: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF for one cycle. Next edge: regf_write_CS=1, rd_add=3, write_data=0xDEADBEEF for exactly one cycle. pending[3]=1 from acceptance until the cycle after the write; fifo_count returns to 0.
- Simultaneous sources with DEPTH=4 and wb_hold=1: ALU (rd=1, 0x11) and load (rd=2, 0x22) both accepted (count=2). Repeat once (count=4); then alu_ready=ld_ready=0. Release hold: four writes in order 1,2,1,2 with matching data.
- Last-slot priority: hold with count=3, both valid. ALU accepted, ld_ready=0. Next cycle count=4, both readies 0.
- x0 drop: alu_rd=0, alu_data=0xFFFFFFFF. alu_ready=1 and handshake completes; fifo_count stays 0, pending stays 0, no regf_write_CS pulse.
- Reset mid-operation: fill 3 entries under hold, assert reset one cycle, release hold. No write pulses, fifo_count=0, pending=0, both readies 1.
- WB_FORWARD_EN: enqueue rd=5/0x1 then rd=5/0x2 under hold, fwd_add=5. fwd_hit=1, fwd_data=0x2. With fwd_add=0: fwd_hit=0. Without the macro: fwd_hit=0 throughout.
